ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter_ram_core.sv | 35 +++
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared defaults, FSM state type and requester-select constants
//               for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam int DW_DEFAULT = 20;
    localparam int AW_DEFAULT = 10;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_ram_core.sv
// ============================================================================
// Module      : ram_core
// Description : Single-port RAM, registered read address, write-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_core #(
    parameter int DW = ram_arbiter_pkg::DW_DEFAULT,
    parameter int AW = ram_arbiter_pkg::AW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [AW-1:0] r_addr;

    // Read goes through the registered address, so a write this cycle is
    // visible to a read of the same word on the next cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_addr <= addr;
    end

    assign rdata = r_mem[r_addr];

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               RAM, with a post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          init_done
);

    localparam logic [AW-1:0] c_last_addr = {AW{1'b1}};
    localparam logic [AW-1:0] c_addr_one  = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_init_cnt;
    logic          r_ptr;
    logic          r_init_done;
    logic          r_a_rvalid;
    logic          r_b_rvalid;

    logic          w_init_last;
    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_wdata;
    logic [DW-1:0] w_ram_rdata;

    assign w_init_last = (r_state == ST_INIT) && (r_init_cnt == c_last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, grant selection and the RAM port mux.
    always_comb begin
        w_state_next = r_state;
        w_a_gnt      = 1'b0;
        w_b_gnt      = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_init_cnt;
        w_ram_wdata  = '0;
        case (r_state)
            ST_INIT: begin
                w_ram_we = 1'b1;
                if (w_init_last) begin
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                w_a_gnt = a_req && (!b_req || (r_ptr == SEL_A));
                w_b_gnt = b_req && (!a_req || (r_ptr == SEL_B));
                if (w_b_gnt) begin
                    w_ram_we    = b_we;
                    w_ram_addr  = b_addr;
                    w_ram_wdata = b_wdata;
                end else begin
                    w_ram_we    = w_a_gnt && a_we;
                    w_ram_addr  = a_addr;
                    w_ram_wdata = a_wdata;
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + c_addr_one;
            if (w_init_last) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // The loser of a grant gets priority next time; idle cycles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SEL_A;
        end else if (w_a_gnt) begin
            r_ptr <= SEL_B;
        end else if (w_b_gnt) begin
            r_ptr <= SEL_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt && !a_we;
            r_b_rvalid <= w_b_gnt && !b_we;
        end
    end

    ram_core #(
        .DW (DW),
        .AW (AW)
    ) u_ram_core (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    assign a_gnt     = w_a_gnt;
    assign b_gnt     = w_b_gnt;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = w_ram_rdata;
    assign b_rdata   = w_ram_rdata;
    assign init_done = r_init_done;

endmodule

`default_nettype wire
